// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the convolution frame controller
package conv_pkg;
    typedef logic [71:0] coef_t;
    typedef enum logic [2:0] {IDLE, INIT, STREAM, DRAIN, DONE} fsm_t;
    function automatic int stream_w(input int img_w);
        return img_w + 2;
    endfunction
endpackage

// File: rtl/conv_pad_gen.sv
// conv_pad_gen: row/col slot counters over the padded stream and pixel/pad slot decode
module conv_pad_gen
    import conv_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int CW    = $clog2(IMG_W + 2)
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic adv,
    output logic pix_slot,
    output logic last_slot
);
    localparam int SW = stream_w(IMG_W);
    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic          last_col;
    assign last_col  = col_q == CW'(SW - 1);
    assign last_slot = last_col && row_q == CW'(SW - 1);
    assign pix_slot  = row_q != '0 && row_q <= CW'(IMG_W) && col_q != '0 && col_q <= CW'(IMG_W);
    always_comb begin
        row_d = clr ? '0 : (adv && last_col) ? row_q + 1'b1 : row_q;
        col_d = clr ? '0 : adv ? (last_col ? '0 : col_q + 1'b1) : col_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
endmodule

// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer that zero-pads the pixel stream for the 3x3 core and tags frame end.
// Optional CONV_CTRL_STATS_EN adds saturating input/output stall counters.
module conv_frame_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cfg_wr,
    input  coef_t       cfg_f,
    output logic        busy,
    output logic        frame_done,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [7:0]  s_x,
    output logic        c_rst,
    output coef_t       c_f,
    output logic        c_valid,
    input  logic        c_ready,
    output logic [7:0]  c_x,
    input  logic        y_valid,
    output logic        y_ready,
    input  logic [7:0]  y_x,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [7:0]  m_y,
    output logic        m_last
`ifdef CONV_CTRL_STATS_EN
    ,
    output logic [31:0] stall_in_cnt,
    output logic [31:0] stall_out_cnt
`endif
);
    localparam int SW   = stream_w(IMG_W);
    localparam int CW   = $clog2(SW);
    localparam int NPIX = IMG_W * IMG_W;
    localparam int OW   = $clog2(NPIX + 1);
    fsm_t          state_q, state_d;
    coef_t         shadow_q, shadow_d, cf_q, cf_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic          pix_slot, last_slot, in_stream, out_act, in_hs, out_hs;
    conv_pad_gen #(.IMG_W(IMG_W), .CW(CW)) u_pad (
        .clk      (clk),
        .reset    (reset),
        .clr      (state_q == INIT),
        .adv      (in_hs),
        .pix_slot (pix_slot),
        .last_slot(last_slot)
    );
    assign in_stream  = state_q == STREAM;
    assign out_act    = in_stream || state_q == DRAIN;
    assign busy       = state_q != IDLE;
    assign frame_done = state_q == DONE;
    assign c_rst      = reset || state_q == INIT;
    assign c_f        = cf_q;
    assign c_valid    = in_stream && (pix_slot ? s_valid : 1'b1);
    assign c_x        = (in_stream && pix_slot) ? s_x : '0;
    assign s_ready    = in_stream && pix_slot && c_ready;
    assign m_valid    = out_act && y_valid;
    assign y_ready    = out_act ? m_ready : 1'b1;
    assign m_y        = y_x;
    assign in_hs      = c_valid && c_ready;
    assign out_hs     = m_valid && m_ready;
    assign m_last     = m_valid && out_cnt_q == OW'(NPIX - 1);
    always_comb begin
        state_d   = state_q;
        shadow_d  = cfg_wr ? cfg_f : shadow_q;
        cf_d      = state_q == INIT ? shadow_q : cf_q;
        out_cnt_d = state_q == INIT ? '0 : out_hs ? out_cnt_q + 1'b1 : out_cnt_q;
        case (state_q)
            IDLE:    state_d = start ? INIT : IDLE;
            INIT:    state_d = STREAM;
            STREAM:  state_d = (out_hs && m_last) ? DONE : (in_hs && last_slot) ? DRAIN : STREAM;
            DRAIN:   state_d = (out_hs && m_last) ? DONE : DRAIN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shadow_q  <= '0;
            cf_q      <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            cf_q      <= cf_d;
            out_cnt_q <= out_cnt_d;
        end
    end
`ifdef CONV_CTRL_STATS_EN
    // Stall conditions can only be true in STREAM/DRAIN, so the counters hold in IDLE.
    logic [31:0] stall_in_q, stall_in_d, stall_out_q, stall_out_d;
    always_comb begin
        stall_in_d  = state_q == INIT ? '0 :
                      stall_in_q + {31'b0, c_valid && !c_ready && stall_in_q != '1};
        stall_out_d = state_q == INIT ? '0 :
                      stall_out_q + {31'b0, m_valid && !m_ready && stall_out_q != '1};
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_in_q  <= '0;
            stall_out_q <= '0;
        end else begin
            stall_in_q  <= stall_in_d;
            stall_out_q <= stall_out_d;
        end
    end
    assign stall_in_cnt  = stall_in_q;
    assign stall_out_cnt = stall_out_q;
`endif
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: randomized frames through a behavioural 3x3 core, checked against a direct convolution model
module tb_conv_frame_ctrl;
    import conv_pkg::*;
    localparam int W  = 4;
    localparam int SW = W + 2;
    localparam int NP = W * W;
    logic       clk = 1'b0;
    logic       reset, start, cfg_wr;
    coef_t      cfg_f, c_f;
    logic       busy, frame_done, s_valid, s_ready, c_rst, c_valid, c_ready;
    logic       y_valid, y_ready, m_valid, m_ready, m_last;
    logic [7:0] s_x, c_x, y_x, m_y;
`ifdef CONV_CTRL_STATS_EN
    logic [31:0] stall_in_cnt, stall_out_cnt;
`endif
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] img [NP];
    logic [7:0] strm [SW*SW];
    coef_t      ones_f, centre_f;

    always #5 clk = ~clk;

    conv_frame_ctrl #(.IMG_W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_wr(cfg_wr), .cfg_f(cfg_f),
        .busy(busy), .frame_done(frame_done), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x),
        .c_rst(c_rst), .c_f(c_f), .c_valid(c_valid), .c_ready(c_ready), .c_x(c_x),
        .y_valid(y_valid), .y_ready(y_ready), .y_x(y_x),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_last(m_last)
`ifdef CONV_CTRL_STATS_EN
        , .stall_in_cnt(stall_in_cnt), .stall_out_cnt(stall_out_cnt)
`endif
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Direct zero-bordered 3x3 convolution of the raw image.
    function automatic logic [7:0] ref_pix(input coef_t f, input int k);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int rr = k / W + i - 1;
                int cc = k % W + j - 1;
                if (rr >= 0 && rr < W && cc >= 0 && cc < W)
                    s += int'($signed(f[8*(3*i+j) +: 8])) * int'(img[rr*W+cc]);
            end
        return s[7:0];
    endfunction

    // Behavioural core: convolves the padded stream it actually received.
    function automatic logic [7:0] core_pix(input coef_t f, input int k);
        int s;
        s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'($signed(f[8*(3*i+j) +: 8])) * int'(strm[(k/W+i)*SW + k%W + j]);
        return s[7:0];
    endfunction

    task automatic set_cfg(input coef_t v);
        cfg_wr = 1'b1;
        cfg_f  = v;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic run_frame(input coef_t expf, input int gap, input bit poke, input int abort_at,
                             input bit wr_mid, input bit stall);
        int  p = 0, nin = 0, nout = 0, npad = 0, nsh = 0, cyc = 0;
        int  last_cyc = -10, done_cyc = -1, stall_left;
        bit  pad;
        stall_left = stall ? 10 : 0;
        s_valid = 1'b0; y_valid = 1'b0; m_ready = 1'b0; c_ready = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        check("init_c_rst", c_rst, 1'b1);
        check("init_busy", busy, 1'b1);
        @(negedge clk);
        while (done_cyc < 0 && cyc < 2000) begin
            if (cyc == abort_at) begin
                reset = 1'b1; s_valid = 1'b0; y_valid = 1'b0;
                #1;
                check("abort_c_rst", c_rst, 1'b1);
                @(negedge clk);
                check("abort_busy", busy, 1'b0);
                check("abort_done", frame_done, 1'b0);
                reset = 1'b0;
                @(negedge clk);
                check("abort_no_done", frame_done, 1'b0);
                check("abort_c_f", c_f, 72'h0);
                return;
            end
            s_valid = $urandom_range(99) >= gap;
            s_x     = p < NP ? img[p] : 8'h00;
            c_ready = $urandom_range(99) >= gap;
            y_valid = nout < NP && nin > (nout / W + 2) * SW + nout % W + 2;
            y_x     = y_valid ? core_pix(c_f, nout) : 8'h00;
            m_ready = (stall_left > 0 && y_valid) ? 1'b0 : ($urandom_range(99) >= gap);
            start   = poke && cyc == 5;
            cfg_wr  = wr_mid && cyc == 7;
            cfg_f   = centre_f;
            #1;
            if (cyc == 0) check("c_f", c_f, expf);
            if (stall_left > 0 && y_valid) stall_left--;
            check("m_valid", m_valid, y_valid);
            pad = nin / SW == 0 || nin / SW == SW - 1 || nin % SW == 0 || nin % SW == SW - 1;
            if (nin == SW * SW) begin
                check("drain_c_valid", c_valid, 1'b0);
                check("drain_s_ready", s_ready, 1'b0);
            end else if (pad) begin
                check("pad_s_ready", s_ready, 1'b0);
                check("pad_c_valid", c_valid, 1'b1);
            end else
                check("pix_c_valid", c_valid, s_valid);
            if (s_valid && s_ready) begin
                nsh++;
                p++;
            end
            if (c_valid && c_ready && nin < SW * SW) begin
                check("c_x", c_x, pad ? 8'h00 : img[(nin/SW-1)*W + nin%SW - 1]);
                if (pad) npad++;
                strm[nin] = c_x;
                nin++;
            end
            if (m_valid && m_ready) begin
                check("m_y", m_y, ref_pix(expf, nout));
                check("m_last", m_last, nout == NP - 1);
                nout++;
                last_cyc = cyc;
            end
            if (frame_done) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0; cfg_wr = 1'b0; s_valid = 1'b0; y_valid = 1'b0;
        check("done_seen", done_cyc >= 0, 1'b1);
        check("done_timing", done_cyc, last_cyc + 1);
        check("n_in", nin, SW * SW);
        check("n_out", nout, NP);
        check("n_pad", npad, SW * SW - NP);
        check("n_s_hs", nsh, NP);
        #1;
        check("idle_busy", busy, 1'b0);
        check("idle_done", frame_done, 1'b0);
    endtask

    initial begin
        ones_f   = {9{8'h01}};
        centre_f = 72'h01 << 32;
        reset = 1'b1; start = 1'b0; cfg_wr = 1'b0; cfg_f = '0;
        s_valid = 1'b0; s_x = '0; c_ready = 1'b0; y_valid = 1'b0; y_x = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", frame_done, 1'b0);
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_c_valid", c_valid, 1'b0);
        check("rst_c_x", c_x, 8'h00);
        check("rst_c_rst", c_rst, 1'b1);
        check("rst_c_f", c_f, 72'h0);
        reset = 1'b0;
        #1;
        check("idle_c_rst", c_rst, 1'b0);
        check("idle_y_ready", y_ready, 1'b1);
        @(negedge clk);
        set_cfg(ones_f);
        for (int k = 0; k < NP; k++) img[k] = 8'h01;
        run_frame(ones_f, 0, 1'b0, -1, 1'b0, 1'b0);
        for (int k = 0; k < NP; k++) img[k] = 8'($urandom_range(255));
        run_frame(ones_f, 30, 1'b1, -1, 1'b1, 1'b0);
        for (int k = 0; k < NP; k++) img[k] = 8'($urandom_range(255));
        run_frame(centre_f, 40, 1'b0, -1, 1'b0, 1'b0);
        run_frame(centre_f, 30, 1'b0, 15, 1'b0, 1'b0);
        set_cfg(centre_f);
        for (int k = 0; k < NP; k++) img[k] = 8'($urandom_range(255));
        run_frame(centre_f, 20, 1'b1, -1, 1'b0, 1'b0);
`ifdef CONV_CTRL_STATS_EN
        run_frame(centre_f, 0, 1'b0, -1, 1'b0, 1'b1);
        check("stall_out_cnt", stall_out_cnt, 32'd10);
        check("stall_in_cnt", stall_in_cnt, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
